// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and types for the hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // Default register index width; the top exposes its own parameter.
  localparam int REG_ADDR_W_DEF = 4;

  // Opcodes of the instructions the hazard logic cares about.
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b01101;
  localparam logic [4:0] OP_LDR  = 5'b10010;

  // Register index at the default width.
  typedef logic [REG_ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_unit_reg_timer.sv
// One scoreboard entry: counts down the cycles until a pending load result is usable.
// Latency: busy reflects a set/clear on the cycle after the edge that applies it.
// Backpressure: none; set overrides clear, which overrides the decrement.
module hazard_reg_timer #(
  parameter int CNT_W    = 1,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  // Reload on a new load, drop on a squashed load, otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard and branch flush control for the IF/ID and ID/EX stages.
// Latency: control outputs are combinational (zero cycles) from state and inputs.
// Backpressure: stalls PC/IF-ID on a busy source; a taken branch flushes and wins over a stall.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int NUM_REGS     = 2**REG_ADDR_W,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int R0_NO_HAZARD = 1,
  parameter int PERF_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifid_valid,
  input  logic [REG_ADDR_W-1:0] rn_ifid,
  input  logic                  rn_used_ifid,
  input  logic [REG_ADDR_W-1:0] rm_ifid,
  input  logic                  rm_used_ifid,
  input  logic [REG_ADDR_W-1:0] rd_ifid,
  input  logic                  is_load_ifid,
  input  logic                  branch_taken_exmem,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;
  logic                  flushing;
  logic                  stall;
  logic                  issue;
  logic                  track_rd;
  logic                  sh_valid;
  logic                  sh_load;
  logic [REG_ADDR_W-1:0] sh_rd;
  logic [FL_W-1:0]       flush_cnt_r;

  assign flushing = branch_taken_exmem | (flush_cnt_r != '0);
  assign stall    = ifid_valid & ~flushing &
                    ((rn_used_ifid & busy[rn_ifid]) | (rm_used_ifid & busy[rm_ifid]));
  assign issue    = ifid_valid & ~stall & ~flushing;
  // R0 is hard-wired zero in most ISAs, so loads into it need no tracking.
  assign track_rd = (rd_ifid != '0) || (R0_NO_HAZARD == 0);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_timer
    assign set_vec[i] = issue & is_load_ifid & track_rd & (rd_ifid == REG_ADDR_W'(i));
    // A load squashed by the branch must not leave its register marked busy.
    assign clr_vec[i] = branch_taken_exmem & sh_valid & sh_load & (sh_rd == REG_ADDR_W'(i));

    hazard_reg_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (LOAD_LAT)
    ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set_vec[i]),
      .clr   (clr_vec[i]),
      .busy  (busy[i])
    );
  end

  // Shadow of the instruction that just moved into ID/EX, used to squash its load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid <= 1'b0;
      sh_rd    <= '0;
      sh_load  <= 1'b0;
    end else begin
      sh_valid <= issue;
      sh_rd    <= rd_ifid;
      sh_load  <= is_load_ifid;
    end
  end

  // Holds the flush for the remaining cycles after a taken branch; a new branch reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= '0;
    end else if (branch_taken_exmem) begin
      flush_cnt_r <= FL_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt_r != '0) begin
      flush_cnt_r <= flush_cnt_r - FL_W'(1);
    end
  end

  // Pipeline control: pass-through in reset, flush beats stall, otherwise run.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    if (rst_n) begin
      if (flushing) begin
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
        ex_mem_flush   = 1'b1;
      end else if (stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  // Saturating event counters for stall cycles and taken-branch cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (branch_taken_exmem && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
